// File: rtl/dq_read_gather_pkg.sv
// Shared types and constants for the DQ read gather slice.
package dq_read_gather_pkg;

    localparam int DLY_STAGES = 16;
    localparam int BL8_W      = 8;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_1    = 2'd1,
        CAP_2    = 2'd2,
        CAP_3    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/dq_gather_fifo.sv
// First-word fall-through FIFO holding assembled read bursts.
module dq_gather_fifo #(
    parameter int W         = 64,
    parameter int FIFO_LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [FIFO_LOG2:0]   CNT_ONE   = 1;
    localparam logic [FIFO_LOG2:0]   CNT_DEPTH = (FIFO_LOG2+1)'(DEPTH);

    logic [W-1:0]         mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2:0]   cnt;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (cnt == CNT_DEPTH);
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // When full, a pop frees the slot the push writes into
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dq_read_gather.sv
// Gathers deserialized DQ nibbles into BL8 lane bytes and queues them.
// Optional burst counter enabled by macro DQ_READ_GATHER_CNT_EN.
module dq_read_gather
    import dq_read_gather_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int FIFO_LOG2 = 2
) (
    input  logic               oclk_div,
    input  logic               rst,
    input  logic [4*LANES-1:0] din,
    input  logic               rd_start,
    input  logic [3:0]         lat,
    input  logic               half_shift,
    output logic [8*LANES-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               overflow,
    output logic               collision,
    input  logic               clr_err
`ifdef DQ_READ_GATHER_CNT_EN
    ,
    output logic [15:0]        burst_cnt
`endif
);

    localparam int W  = BL8_W * LANES;
    localparam int NW = 4 * LANES;

    localparam logic [1:0] S_IDLE = CAP_IDLE;
    localparam logic [1:0] S_CAP1 = CAP_1;
    localparam logic [1:0] S_CAP2 = CAP_2;
    localparam logic [1:0] S_CAP3 = CAP_3;

    logic [DLY_STAGES-1:0] dly;
    logic [NW-1:0]         din_q;
    logic [NW-1:0]         n1;
    logic [NW-1:0]         n2;
    logic                  hs_q;
    logic [1:0]            state;
    logic                  trig;
    logic                  busy;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [W-1:0]          word;

    assign trig = dly[lat];
    assign busy = (state == S_CAP1) || (state == S_CAP2 && hs_q);
    assign push = (state == S_CAP2 && !hs_q) || (state == S_CAP3);

    // din is registered once, so each state captures the previous cycle's nibble
    always_ff @(posedge oclk_div) begin
        if (rst) begin
            dly   <= '0;
            din_q <= '0;
            n1    <= '0;
            n2    <= '0;
            hs_q  <= 1'b0;
            state <= S_IDLE;
        end else begin
            dly   <= {dly[DLY_STAGES-2:0], rd_start};
            din_q <= din;
            if (state == S_CAP1)
                n1 <= din_q;
            if (state == S_CAP2)
                n2 <= din_q;
            if (trig && !busy) begin
                state <= S_CAP1;
                hs_q  <= half_shift;
            end else begin
                case (state)
                    S_CAP1:  state <= S_CAP2;
                    S_CAP2:  state <= hs_q ? S_CAP3 : S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (hs_q)
                word[8*i +: 8] = {din_q[4*i +: 2], n2[4*i +: 4], n1[4*i+2 +: 2]};
            else
                word[8*i +: 8] = {din_q[4*i +: 4], n1[4*i +: 4]};
        end
    end

    assign dout_valid = !empty;
    assign pop        = !empty && dout_ready;

    dq_gather_fifo #(
        .W         (W),
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (oclk_div),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (dout),
        .full  (full),
        .empty (empty)
    );

    // Setting wins over a same-cycle clear
    always_ff @(posedge oclk_div) begin
        if (rst) begin
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (trig && busy)
                collision <= 1'b1;
            else if (clr_err)
                collision <= 1'b0;
        end
    end

`ifdef DQ_READ_GATHER_CNT_EN
    always_ff @(posedge oclk_div) begin
        if (rst)
            burst_cnt <= '0;
        else if (push && (!full || pop))
            burst_cnt <= burst_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dq_read_gather.sv
// Directed self-checking bench for dq_read_gather.
module tb_dq_read_gather;

    localparam int LANES = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [4*LANES-1:0] din;
    logic               rd_start;
    logic [3:0]         lat;
    logic               half_shift;
    logic [8*LANES-1:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               overflow;
    logic               collision;
    logic               clr_err;
`ifdef DQ_READ_GATHER_CNT_EN
    logic [15:0]        burst_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dq_read_gather #(.LANES(LANES), .FIFO_LOG2(2)) dut (
        .oclk_div   (clk),
        .rst        (rst),
        .din        (din),
        .rd_start   (rd_start),
        .lat        (lat),
        .half_shift (half_shift),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .collision  (collision),
        .clr_err    (clr_err)
`ifdef DQ_READ_GATHER_CNT_EN
        ,
        .burst_cnt  (burst_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_one();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        din = '0;
        rd_start = 1'b0;
        lat = 4'd0;
        half_shift = 1'b0;
        dout_ready = 1'b0;
        clr_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_coll", 64'(collision), 64'd0);

        // lat=3, aligned burst, distinct lanes
        lat = 4'd3;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        tick();
        din = 32'h7654321A;
        tick();
        din = 32'hFEDCBA95;
        check("s1_c5_valid", 64'(dout_valid), 64'd0);
        tick();
        din = '0;
        check("s1_c6_valid", 64'(dout_valid), 64'd0);
        tick();
        check("s1_c7_valid", 64'(dout_valid), 64'd1);
        check("s1_c7_dout", dout, 64'hF7E6D5C4B3A2915A);
        pop_one();
        check("s1_empty", 64'(dout_valid), 64'd0);
        check("s1_empty_dout", dout, 64'd0);

        // half_shift burst; half_shift drops after trigger
        lat = 4'd0;
        half_shift = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        din = {LANES{4'hC}};
        tick();
        half_shift = 1'b0;
        din = {LANES{4'h3}};
        tick();
        din = {LANES{4'h2}};
        tick();
        din = '0;
        check("s2_c4_valid", 64'(dout_valid), 64'd0);
        tick();
        check("s2_valid", 64'(dout_valid), 64'd1);
        check("s2_dout", dout, {LANES{8'h8F}});
        pop_one();

        // back-to-back bursts every 2 cycles, streaming out
        dout_ready = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            rd_start = (c <= 6) && (c % 2 == 0);
            din = {LANES{4'(c)}};
            if (c == 4 || c == 6 || c == 8 || c == 10) begin
                b = {4'(c - 2), 4'(c - 3)};
                check("s3_valid", 64'(dout_valid), 64'd1);
                check("s3_dout", dout, {LANES{b}});
            end else if (c % 2 == 1) begin
                check("s3_gap", 64'(dout_valid), 64'd0);
            end
            tick();
        end
        rd_start = 1'b0;
        din = '0;
        dout_ready = 1'b0;
        check("s3_coll", 64'(collision), 64'd0);

        // collision: second trigger one cycle late
        rd_start = 1'b1;
        tick();
        din = {LANES{4'h1}};
        tick();
        rd_start = 1'b0;
        din = {LANES{4'h2}};
        tick();
        din = '0;
        check("s4_coll_set", 64'(collision), 64'd1);
        tick();
        check("s4_valid", 64'(dout_valid), 64'd1);
        check("s4_dout", dout, {LANES{8'h21}});
        pop_one();
        check("s4_one_word", 64'(dout_valid), 64'd0);
        tick();
        check("s4_no_word", 64'(dout_valid), 64'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("s4_coll_clr", 64'(collision), 64'd0);

        // set and clear in the same cycle keeps the flag
        rd_start = 1'b1;
        tick();
        tick();
        rd_start = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("s4_set_wins", 64'(collision), 64'd1);
        tick();
        pop_one();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("s4_coll_clr2", 64'(collision), 64'd0);
        check("s4_drained", 64'(dout_valid), 64'd0);

        // overflow: five bursts into a held FIFO
        for (int c = 0; c <= 11; c++) begin
            rd_start = (c <= 8) && (c % 2 == 0);
            din = {LANES{4'(c)}};
            if (c == 11)
                check("s5_no_ovf_yet", 64'(overflow), 64'd0);
            tick();
        end
        rd_start = 1'b0;
        din = '0;
        check("s5_ovf", 64'(overflow), 64'd1);
        check("s5_valid", 64'(dout_valid), 64'd1);
`ifdef DQ_READ_GATHER_CNT_EN
        check("s5_cnt", 64'(burst_cnt), 64'd12);
`endif
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b = {4'(2 * k + 2), 4'(2 * k + 1)};
            check("s5_drain", dout, {LANES{b}});
            tick();
        end
        dout_ready = 1'b0;
        check("s5_empty", 64'(dout_valid), 64'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("s5_ovf_clr", 64'(overflow), 64'd0);

        // reset during CAP2 discards the partial word
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        din = {LANES{4'h1}};
        tick();
        din = {LANES{4'h2}};
        tick();
        rst = 1'b1;
        din = '0;
        tick();
        rst = 1'b0;
        check("s6_valid_a", 64'(dout_valid), 64'd0);
        check("s6_dout", dout, 64'd0);
`ifdef DQ_READ_GATHER_CNT_EN
        check("s6_cnt_rst", 64'(burst_cnt), 64'd0);
`endif
        tick();
        check("s6_valid_b", 64'(dout_valid), 64'd0);
        tick();
        check("s6_valid_c", 64'(dout_valid), 64'd0);

        // fresh burst after reset, lat=2 with half_shift
        lat = 4'd2;
        half_shift = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        din = {LANES{4'hC}};
        tick();
        din = {LANES{4'h3}};
        tick();
        din = {LANES{4'h2}};
        tick();
        din = '0;
        check("s6_c6_valid", 64'(dout_valid), 64'd0);
        tick();
        check("s6_post_valid", 64'(dout_valid), 64'd1);
        check("s6_post_dout", dout, {LANES{8'h8F}});
`ifdef DQ_READ_GATHER_CNT_EN
        check("s6_cnt", 64'(burst_cnt), 64'd1);
`endif
        check("s6_ovf", 64'(overflow), 64'd0);
        check("s6_coll", 64'(collision), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dq_read_gather.md
DQ_READ_GATHER -- requirements
Module: dq_read_gather

Interface
REQ-001 SHALL have parameter LANES, default 8: number of DQ lanes per byte group.
REQ-002 SHALL have parameter FIFO_LOG2, default 2: log2 of the output FIFO depth (4 words).
REQ-003 SHALL have port oclk_div, input, 1: the only clock, the memory-interface divided clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port din, input, 4*LANES: per-lane deserialized nibbles; lane i occupies [4i+3:4i], bit 0 earliest in time.
REQ-006 SHALL have port rd_start, input, 1: one-cycle pulse from the sequencer marking an issued BL8 read.
REQ-007 SHALL have port lat, input, 4: cycles from rd_start to the first data nibble.
REQ-008 SHALL have port half_shift, input, 1: the burst begins at nibble bit 2 rather than bit 0.
REQ-009 SHALL have port dout, output, 8*LANES: an assembled burst; lane i occupies [8i+7:8i], bit 0 earliest.
REQ-010 SHALL have ports dout_valid (output, 1) and dout_ready (input, 1): FIFO read handshake.
REQ-011 SHALL have ports overflow (output, 1), collision (output, 1) and clr_err (input, 1): sticky error flags and their clear.

Function
REQ-012 SHALL delay each rd_start marker through a 16-stage shift register; the marker at tap lat (0 = next cycle) triggers capture.
REQ-013 With half_shift=0, SHALL capture nibbles N1 and N2 on the trigger cycle and the following cycle; lane word = {N2,N1}.
REQ-014 With half_shift=1, SHALL capture N1, N2 and N3 on three consecutive cycles; lane word = {N3[1:0],N2,N1[3:2]}.
REQ-015 SHALL push the assembled word into the FIFO on the cycle after the last captured nibble; dout_valid rises on the next cycle.
REQ-016 Capture FSM states: IDLE, CAP1, CAP2, CAP3 (CAP3 only with half_shift=1); a trigger in IDLE or in the final state enters CAP1, so bursts can run back-to-back every 2 (or 3) cycles.
REQ-017 A trigger arriving in any non-final capture state SHALL be discarded and SHALL set collision.
REQ-018 half_shift and lat SHALL be sampled per marker at trigger time; a change while markers are in flight affects only later triggers.
REQ-019 The FIFO SHALL be first-word fall-through: dout is valid whenever dout_valid=1; a pop occurs when dout_valid && dout_ready.
REQ-020 A push to a full FIFO SHALL drop the word and set overflow; a simultaneous push and pop when full SHALL accept both.
REQ-021 An empty FIFO SHALL hold dout_valid=0 whatever the state of dout_ready.
REQ-022 clr_err SHALL clear both flags; a set and a clear in the same cycle SHALL leave the flag set.

Reset
REQ-023 On rst, SHALL clear the delay line, return the FSM to IDLE, empty the FIFO, and drive dout_valid=0, overflow=0, collision=0 and dout=0.
REQ-024 rst asserted mid-burst SHALL discard the partial word; no push SHALL occur on the cycle after rst deasserts.

Configuration
REQ-025 With macro DQ_READ_GATHER_CNT_EN defined, SHALL add output burst_cnt, 16 bits: counts accepted pushes, wraps at 0xFFFF->0, cleared by rst.
REQ-026 Without DQ_READ_GATHER_CNT_EN, burst_cnt SHALL not exist and the logic SHALL be identical otherwise.

Structure
REQ-027 The shared package SHALL hold the capture-state enum, the constant DLY_STAGES=16, and the BL8 width constant (8 bits per lane).
REQ-028 The FIFO SHALL be a sub-module named dq_gather_fifo, parameterized by width and FIFO_LOG2, providing full/empty outputs.

Verification
REQ-029 Scenario: lat=3, half_shift=0, rd_start at cycle 0, lane0 nibbles 0xA at cycle 4 and 0x5 at cycle 5 -> dout[7:0]=0x5A with dout_valid at cycle 7.
REQ-030 Scenario: half_shift=1, lane0 nibbles 0xC, 0x3, 0x2 -> dout[7:0]=0x8F.
REQ-031 Scenario: rd_start at cycles 0, 2, 4, 6 with lat=0 and dout_ready=1 -> four words in order with no collision.
REQ-032 Scenario: rd_start at cycles 0 and 1 -> one word and collision=1; clr_err -> collision=0.
REQ-033 Scenario: dout_ready=0 and 5 bursts -> 4 words held and overflow=1; then drain -> words 1-4 in order.
REQ-034 Scenario: rst at the CAP2 cycle -> no word, dout_valid=0, and the next burst after reset assembles correctly.
